// File: rtl/mac_pkg.sv
// Shared types and constant helpers for the mac_dot_product engine.
// Saturating accumulation is selected by defining MAC_SATURATE_EN.
package mac_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mac_state_e;

    function automatic int acc_width(input int data_w, input int guard_w);
        return 2 * data_w + guard_w;
    endfunction

    // Clamp limits are returned 64 bits wide; callers keep the low acc_w bits.
    function automatic logic [63:0] sat_max(input int acc_w, input bit is_signed);
        logic [63:0] one;
        one = 64'd1;
        if (is_signed) begin
            return (one << (acc_w - 1)) - 64'd1;
        end else begin
            return (one << acc_w) - 64'd1;
        end
    endfunction

    function automatic logic [63:0] sat_min(input int acc_w, input bit is_signed);
        logic [63:0] one;
        one = 64'd1;
        if (is_signed) begin
            return ~((one << (acc_w - 1)) - 64'd1);
        end else begin
            return 64'd0;
        end
    endfunction

endpackage

// File: rtl/mac_mult_stage.sv
// Stage-1 multiplier register of mac_dot_product: registers i_a*i_b with
// its valid/last tags and holds everything while i_hold is high.
module mac_mult_stage
    import mac_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int SIGNED = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_hold,
    input  logic                  i_valid,
    input  logic                  i_last,
    input  logic [DATA_W-1:0]     i_a,
    input  logic [DATA_W-1:0]     i_b,
    output logic [2*DATA_W-1:0]   o_p,
    output logic                  o_valid,
    output logic                  o_last
);

    localparam int PW = 2 * DATA_W;

    logic [PW-1:0] w_a;
    logic [PW-1:0] w_b;
    logic [PW-1:0] w_prod;
    logic          w_a_ext;
    logic          w_b_ext;

    logic [PW-1:0] r_p;
    logic          r_valid;
    logic          r_last;

    // Extending both operands to the product width makes the truncated
    // unsigned product equal to the two's-complement product.
    assign w_a_ext = (SIGNED != 0) ? i_a[DATA_W-1] : 1'b0;
    assign w_b_ext = (SIGNED != 0) ? i_b[DATA_W-1] : 1'b0;
    assign w_a     = {{DATA_W{w_a_ext}}, i_a};
    assign w_b     = {{DATA_W{w_b_ext}}, i_b};
    assign w_prod  = w_a * w_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p     <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else if (!i_hold) begin
            r_p     <= w_prod;
            r_valid <= i_valid;
            r_last  <= i_valid & i_last;
        end
    end

    assign o_p     = r_p;
    assign o_valid = r_valid;
    assign o_last  = r_last;

endmodule

// File: rtl/mac_dot_product.sv
// Pipelined multiply-accumulate dot-product engine with valid/ready on both sides.
// Define MAC_SATURATE_EN for clamping accumulation with a sticky sat flag.
module mac_dot_product
    import mac_pkg::*;
#(
    parameter int  DATA_W  = 4,
    parameter int  GUARD_W = 4,
    parameter int  CNT_W   = 4,
    parameter int  SIGNED  = 0,
    localparam int ACC_W   = acc_width(DATA_W, GUARD_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] i,
    input  logic [DATA_W-1:0] j,
    input  logic [CNT_W-1:0]  len,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  f,
    output logic              sat
);

    localparam int PW = 2 * DATA_W;

    logic             w_stall;
    logic             w_in_xfer;
    logic             w_last;
    logic [CNT_W-1:0] w_cnt_next;

    mac_state_e       r_state;
    logic [CNT_W-1:0] r_len_q;
    logic [CNT_W-1:0] r_cnt;

    logic [PW-1:0]    w_p;
    logic             w_p_valid;
    logic             w_p_last;
    logic             w_p_sign;
    logic [ACC_W-1:0] w_p_ext;
    logic [ACC_W-1:0] w_acc_next;

    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] r_f;
    logic             r_out_valid;

    assign w_stall    = r_out_valid & ~out_ready;
    assign in_ready   = ~w_stall;
    assign w_in_xfer  = in_valid & ~w_stall;
    assign w_cnt_next = r_cnt + CNT_W'(1);

    // Flags the element being offered as the last one of its vector.
    always_comb begin
        w_last = 1'b0;
        case (r_state)
            IDLE:    w_last = (len == '0);
            RUN:     w_last = (w_cnt_next == r_len_q);
            default: w_last = 1'b0;
        endcase
    end

    // Element-counting FSM; len is only looked at on a vector's first element.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_len_q <= '0;
            r_cnt   <= '0;
        end else if (w_in_xfer) begin
            case (r_state)
                IDLE: begin
                    r_len_q <= len;
                    r_cnt   <= '0;
                    r_state <= (len == '0) ? IDLE : RUN;
                end
                RUN: begin
                    r_cnt <= w_cnt_next;
                    if (w_last) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    mac_mult_stage #(
        .DATA_W (DATA_W),
        .SIGNED (SIGNED)
    ) u_mult (
        .clk     (clk),
        .rst     (rst),
        .i_hold  (w_stall),
        .i_valid (w_in_xfer),
        .i_last  (w_last),
        .i_a     (i),
        .i_b     (j),
        .o_p     (w_p),
        .o_valid (w_p_valid),
        .o_last  (w_p_last)
    );

    assign w_p_sign = (SIGNED != 0) ? w_p[PW-1] : 1'b0;

    // Product widened to the accumulator (works for GUARD_W of zero too).
    always_comb begin
        w_p_ext         = {ACC_W{w_p_sign}};
        w_p_ext[PW-1:0] = w_p;
    end

`ifdef MAC_SATURATE_EN
    localparam logic [63:0]      SAT_MAX_FULL = sat_max(ACC_W, SIGNED != 0);
    localparam logic [63:0]      SAT_MIN_FULL = sat_min(ACC_W, SIGNED != 0);
    localparam logic [ACC_W-1:0] SAT_MAX      = SAT_MAX_FULL[ACC_W-1:0];
    localparam logic [ACC_W-1:0] SAT_MIN      = SAT_MIN_FULL[ACC_W-1:0];

    logic [ACC_W:0] w_sum;
    logic           w_acc_sign;
    logic           w_clamp;
    logic           r_sat_flag;
    logic           r_sat;

    assign w_acc_sign = (SIGNED != 0) ? r_acc[ACC_W-1] : 1'b0;

    // One guard bit above ACC_W exposes overflow of this accumulate step.
    always_comb begin
        w_sum      = {w_acc_sign, r_acc} + {w_p_sign, w_p_ext};
        w_acc_next = w_sum[ACC_W-1:0];
        w_clamp    = 1'b0;
        if (SIGNED != 0) begin
            if (w_sum[ACC_W] != w_sum[ACC_W-1]) begin
                w_clamp    = 1'b1;
                w_acc_next = w_sum[ACC_W] ? SAT_MIN : SAT_MAX;
            end else begin
                w_clamp    = 1'b0;
                w_acc_next = w_sum[ACC_W-1:0];
            end
        end else begin
            if (w_sum[ACC_W]) begin
                w_clamp    = 1'b1;
                w_acc_next = SAT_MAX;
            end else begin
                w_clamp    = 1'b0;
                w_acc_next = w_sum[ACC_W-1:0];
            end
        end
    end

    // Sticky per-vector clamp flag, published alongside f.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sat_flag <= 1'b0;
            r_sat      <= 1'b0;
        end else if (!w_stall && w_p_valid) begin
            if (w_p_last) begin
                r_sat      <= r_sat_flag | w_clamp;
                r_sat_flag <= 1'b0;
            end else begin
                r_sat_flag <= r_sat_flag | w_clamp;
            end
        end
    end

    assign sat = r_sat;
`else
    // Plain modulo-2**ACC_W accumulation.
    always_comb begin
        w_acc_next = r_acc + w_p_ext;
    end

    assign sat = 1'b0;
`endif

    // Accumulator and result register; the last product goes straight to f
    // so the next vector can start accumulating onto zero without a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc       <= '0;
            r_f         <= '0;
            r_out_valid <= 1'b0;
        end else if (!w_stall) begin
            r_out_valid <= w_p_valid & w_p_last;
            if (w_p_valid) begin
                if (w_p_last) begin
                    r_f   <= w_acc_next;
                    r_acc <= '0;
                end else begin
                    r_acc <= w_acc_next;
                end
            end
        end
    end

    assign f         = r_f;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_mac_dot_product.sv
// Self-checking bench for mac_dot_product: three configurations (unsigned,
// signed, unsigned with no guard bits) share one input stream.
module tb_mac_dot_product;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] a_i = 4'd0;
    logic [3:0] b_j = 4'd0;
    logic [3:0] len_i = 4'd0;
    logic       out_ready = 1'b1;

    logic        in_ready_u, in_ready_s, in_ready_g;
    logic        out_valid_u, out_valid_s, out_valid_g;
    logic [11:0] f_u, f_s;
    logic [7:0]  f_g;
    logic        sat_u, sat_s, sat_g;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mac_dot_product #(.DATA_W(4), .GUARD_W(4), .CNT_W(4), .SIGNED(0)) u_dut_u (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_u),
        .i(a_i), .j(b_j), .len(len_i), .out_valid(out_valid_u),
        .out_ready(out_ready), .f(f_u), .sat(sat_u));

    mac_dot_product #(.DATA_W(4), .GUARD_W(4), .CNT_W(4), .SIGNED(1)) u_dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .i(a_i), .j(b_j), .len(len_i), .out_valid(out_valid_s),
        .out_ready(out_ready), .f(f_s), .sat(sat_s));

    mac_dot_product #(.DATA_W(4), .GUARD_W(0), .CNT_W(4), .SIGNED(0)) u_dut_g (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_g),
        .i(a_i), .j(b_j), .len(len_i), .out_valid(out_valid_g),
        .out_ready(out_ready), .f(f_g), .sat(sat_g));

    // Reference model: integer dot products per vector, then a two-slot
    // result pipe (in flight -> presented) that freezes while stalled.
    bit          m_idle = 1'b1;
    int          m_len = 0, m_idx = 0;
    int          su = 0, ss = 0, sg = 0;
    bit          satu = 1'b0, sats = 1'b0, satg = 1'b0;
    bit          m_pend = 1'b0;
    logic [11:0] p_fu = 12'd0, p_fs = 12'd0;
    logic [7:0]  p_fg = 8'd0;
    bit          p_su = 1'b0, p_ss = 1'b0, p_sg = 1'b0;
    bit          m_ov = 1'b0;
    logic [11:0] m_fu = 12'd0, m_fs = 12'd0;
    logic [7:0]  m_fg = 8'd0;
    bit          m_su = 1'b0, m_ss = 1'b0, m_sg = 1'b0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic acc_step(inout int acc, input int add, input int lo, input int hi, inout bit s);
        int v;
        v = acc + add;
`ifdef MAC_SATURATE_EN
        if (v > hi) begin
            v = hi;
            s = 1'b1;
        end else if (v < lo) begin
            v = lo;
            s = 1'b1;
        end
`endif
        acc = v;
    endtask

    task automatic model_elem(input logic [3:0] a, input logic [3:0] b, input logic [3:0] l);
        int ua, ub, sa, sb;
        ua = a;
        ub = b;
        sa = (ua > 7) ? ua - 16 : ua;
        sb = (ub > 7) ? ub - 16 : ub;
        if (m_idle) begin
            m_len = l;
            m_idx = 0;
            su = 0; ss = 0; sg = 0;
            satu = 1'b0; sats = 1'b0; satg = 1'b0;
        end else begin
            m_idx++;
        end
        acc_step(su, ua * ub, 0, 4095, satu);
        acc_step(ss, sa * sb, -2048, 2047, sats);
        acc_step(sg, ua * ub, 0, 255, satg);
        if (m_idx == m_len) begin
            m_idle = 1'b1;
            m_pend = 1'b1;
            p_fu = su[11:0]; p_fs = ss[11:0]; p_fg = sg[7:0];
            p_su = satu; p_ss = sats; p_sg = satg;
        end else begin
            m_idle = 1'b0;
        end
    endtask

    task automatic model_clear();
        m_idle = 1'b1; m_pend = 1'b0; m_ov = 1'b0;
        m_fu = 12'd0; m_fs = 12'd0; m_fg = 8'd0;
        m_su = 1'b0; m_ss = 1'b0; m_sg = 1'b0;
    endtask

    task automatic check_outputs();
        chk("out_valid_u", out_valid_u, m_ov);
        chk("out_valid_s", out_valid_s, m_ov);
        chk("out_valid_g", out_valid_g, m_ov);
        chk("f_u", f_u, m_fu);
        chk("f_s", f_s, m_fs);
        chk("f_g", f_g, m_fg);
        chk("sat_u", sat_u, m_su);
        chk("sat_s", sat_s, m_ss);
        chk("sat_g", sat_g, m_sg);
    endtask

    // One clock: drive after an edge, check in_ready before the next edge,
    // advance the model across the edge, then check the outputs.
    task automatic cycle(input bit v, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] l, input bit ordy, output bit accepted);
        bit exp_ir;
        in_valid  = v;
        a_i       = a;
        b_j       = b;
        len_i     = l;
        out_ready = ordy;
        #3;
        exp_ir = !(m_ov && !ordy);
        chk("in_ready_u", in_ready_u, exp_ir);
        chk("in_ready_s", in_ready_s, exp_ir);
        chk("in_ready_g", in_ready_g, exp_ir);
        accepted = v && exp_ir;
        @(posedge clk);
        #1;
        if (exp_ir) begin
            m_ov = m_pend;
            if (m_pend) begin
                m_fu = p_fu; m_fs = p_fs; m_fg = p_fg;
                m_su = p_su; m_ss = p_ss; m_sg = p_sg;
            end
            m_pend = 1'b0;
        end
        if (accepted) model_elem(a, b, l);
        check_outputs();
    endtask

    task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [3:0] l, input bit ordy);
        bit acc;
        cycle(1'b1, a, b, l, ordy, acc);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int k = 0; k < n; k++) cycle(1'b0, 4'd0, 4'd0, 4'd0, 1'b1, acc);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst = 1'b1;
        #2;
        model_clear();
        check_outputs();
        chk("in_ready_rst", in_ready_u, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_outputs();
    endtask

    initial begin
        bit          acc;
        bit          have;
        logic [3:0]  ra, rb, rl;
        bit          rv, ro;

        do_reset();

        // Unsigned len=3: 100+78+18+20 = 216
        send(4'd10, 4'd10, 4'd3, 1'b1);
        send(4'd13, 4'd6,  4'd3, 1'b1);
        send(4'd9,  4'd2,  4'd3, 1'b1);
        send(4'd5,  4'd4,  4'd3, 1'b1);
        idle(3);

        // Signed len=1: (-3*5) + (2*-4) = -23
        send(4'hD, 4'd5, 4'd1, 1'b1);
        send(4'd2, 4'hC, 4'd1, 1'b1);
        idle(2);

        // Back-to-back single-element vectors: 9 then 10
        send(4'd3, 4'd3, 4'd0, 1'b1);
        send(4'd2, 4'd5, 4'd0, 1'b1);
        idle(3);

        // No guard bits: 450 wraps to 194, or clamps to 255 with sat
        send(4'd15, 4'd15, 4'd1, 1'b1);
        send(4'd15, 4'd15, 4'd1, 1'b1);
        idle(2);

        // Back-pressure: result held for 3 cycles while a new element waits
        send(4'd1, 4'd2, 4'd1, 1'b1);
        send(4'd3, 4'd4, 4'd1, 1'b1);
        send(4'd5, 4'd6, 4'd0, 1'b0);
        send(4'd7, 4'd1, 4'd0, 1'b0);
        send(4'd7, 4'd1, 4'd0, 1'b0);
        send(4'd7, 4'd1, 4'd0, 1'b0);
        send(4'd7, 4'd1, 4'd0, 1'b1);
        idle(3);

        // Reset mid-vector, then a fresh len=0 vector: 16
        send(4'd1, 4'd1, 4'd3, 1'b1);
        send(4'd2, 4'd2, 4'd3, 1'b1);
        do_reset();
        idle(2);
        send(4'd4, 4'd4, 4'd0, 1'b1);
        idle(3);

        // Random traffic with random back-pressure; data held until accepted
        have = 1'b0;
        ra = 4'd0; rb = 4'd0; rl = 4'd0;
        for (int n = 0; n < 600; n++) begin
            if (!have) begin
                ra = 4'($urandom_range(0, 15));
                rb = 4'($urandom_range(0, 15));
                rl = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
                have = 1'b1;
            end
            rv = ($urandom_range(0, 3) != 0);
            ro = ($urandom_range(0, 3) != 0);
            cycle(rv, ra, rb, rl, ro, acc);
            if (acc) have = 1'b0;
        end
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
